resp_grant_responder: RTL and testbench
=======================================

# resp_grant_responder

Responder end of the RESP request/grant handshake. Watches up to NUM_REQ requesters, picks one by round-robin, and drives that requester's grant high exactly GNT_DLY cycles after its request is first sampled. It then drops grant one cycle after the requester deasserts request. It sits between the requesting masters and the shared resource and is the producer of the sequence `request ##3 grant ##1 !request ##1 !grant`.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- GNT_DLY, 3: cycles from first sampled request to first sampled grant (2..15).
- MAX_HOLD, 8: cycles grant may stay high while request stays high before timeout (1..255).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- request  in  NUM_REQ  per-requester request, level.
- grant  out  NUM_REQ  one-hot-or-zero grant, registered.
- busy  out  1  high whenever FSM is not IDLE.
- owner  out  $clog2(NUM_REQ)  index of the requester being served; valid while busy.
- abort_p  out  1  one-cycle pulse: owner dropped request before grant.
- timeout_p  out  1  one-cycle pulse: MAX_HOLD exceeded, grant forcibly removed.

## Operation

- States: IDLE, WAIT, GRANT, BACKOFF.
- IDLE: if any request bit is high, select via round-robin starting at last_owner+1, latch owner, set cnt=1, go to WAIT. If no request bit is high, stay.
- WAIT: if request[owner]=0, pulse abort_p and go to IDLE. Else if cnt==GNT_DLY-1, set grant[owner]=1, hold=0 and go to GRANT. Else cnt++.
- GRANT: if request[owner]=0, clear grant, update last_owner=owner, go to IDLE. Else if hold==MAX_HOLD, clear grant, pulse timeout_p, go to BACKOFF. Else hold++.
- BACKOFF: grant stays low; when request[owner]=0, update last_owner and go to IDLE.
- Requests of non-owners are ignored while busy. No queueing.
- cnt is 4 bits and hold is 8 bits; both clear on entry to IDLE.

## Timing

- Reset (async assert, sync release): state=IDLE, grant=0, busy=0, owner=0, abort_p=0, timeout_p=0, last_owner=NUM_REQ-1, so requester 0 wins first. Counters clear.
- Reset mid-operation: grant drops immediately with no pulse.
- Nominal sequence, with request first sampled high at edge N and GNT_DLY=3:
  - grant sampled 0 at N+1 and N+2, and 1 at N+3.
  - Requester holds request through N+3 and drops it for N+4.
  - Grant is still sampled 1 at N+4 and 0 at N+5.
- Earliest next arbitration is edge N+5, so the earliest next grant is sampled at N+5+GNT_DLY.
- Abort: request low at any edge in WAIT ends service that cycle. abort_p is high for exactly the next cycle, and no grant is issued.
- Timeout: grant sampled high for MAX_HOLD+1 consecutive edges with request high. timeout_p and grant=0 then appear in the same cycle.
- Simultaneous requests in IDLE: the lowest index at or after last_owner+1 (wrapping) wins. Losers must keep request held and are served later.
- busy rises the cycle after the winning request is sampled and falls the cycle after the release/abort edge.

## Configuration

- RESP_STATS_EN defined: adds outputs grant_cnt, abort_cnt and timeout_cnt, each 16 bits.
  - Each counts completed grants, aborts and timeouts respectively.
  - All saturate at 16'hFFFF and reset to 0.
- RESP_STATS_EN undefined: these ports and counters are absent, and the remaining behaviour is identical.

## Structure

- Package resp_pkg: state enum resp_state_t (IDLE, WAIT, GRANT, BACKOFF), default constants RESP_GNT_DLY=3 and RESP_MAX_HOLD=8.
- Sub-module rr_arbiter: combinational round-robin pick. Inputs are req[NUM_REQ] and last_owner; outputs are a valid flag and the winning index. It is used only in IDLE.

## Test plan

- Single requester 0, GNT_DLY=3: request high at edge 20ns and held through 50ns, dropped at 60ns -> grant[0] sampled 0,0,1,1,0 at 30,40,50,60,70ns; abort_p=0, timeout_p=0.
- Abort: request[1] high for 2 cycles then low -> no grant, abort_p high for exactly one cycle, busy returns to 0, abort_cnt=1 (with RESP_STATS_EN).
- Fairness: request[0] and request[2] held continuously from reset, each requester dropping request one cycle after its grant and re-raising it once grant falls -> grants alternate 0,2,0,2 and are never simultaneous.
- Timeout with MAX_HOLD=8: request[3] held forever -> grant[3] high for 9 sampled edges, then timeout_p=1 with grant=0. No new grant until request[3] drops and is re-raised.
- Reset mid-GRANT: rst_n low while grant[0]=1 -> grant=0 and busy=0 immediately; after release, a new request gets grant exactly 3 cycles later.
- Bench property check: request ##GNT_DLY grant ##1 !request ##1 !grant holds for every served transaction in the scenarios above.

Source files
------------

// File: rtl/resp_grant_responder_pkg.sv
// rtl/resp_grant_responder_pkg.sv - state type, default timing constants and width helper for the RESP responder
package resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT,
        BACKOFF
    } resp_state_t;

    localparam int RESP_NUM_REQ  = 4;
    localparam int RESP_GNT_DLY  = 3;
    localparam int RESP_MAX_HOLD = 8;

    // Index width that stays legal for a single-requester build.
    function automatic int resp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resp_grant_responder_if.sv
// rtl/resp_grant_responder_if.sv - request/grant bus between the requesting masters and the responder
interface resp_grant_responder_if #(
    parameter int NUM_REQ = resp_pkg::RESP_NUM_REQ
);
    import resp_pkg::*;

    localparam int IW = resp_idx_w(NUM_REQ);

    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic [IW-1:0]      owner;
    logic               abort_p;
    logic               timeout_p;

    modport master (
        output request,
        input  grant, busy, owner, abort_p, timeout_p
    );

    modport slave (
        input  request,
        output grant, busy, owner, abort_p, timeout_p
    );

endinterface

// File: rtl/resp_grant_responder_rr_arbiter.sv
// rtl/resp_grant_responder_rr_arbiter.sv - combinational round-robin pick starting just after last_owner
module rr_arbiter
    import resp_pkg::*;
#(
    parameter  int NUM_REQ = RESP_NUM_REQ,
    localparam int IW      = resp_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_owner_i,
    output logic               valid_o,
    output logic [IW-1:0]      idx_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after last_owner wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(last_owner_i) + i) % NUM_REQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/resp_grant_responder.sv
// rtl/resp_grant_responder.sv - RESP responder FSM: round-robin request, delayed grant, abort/timeout; RESP_STATS_EN adds event counters
module resp_grant_responder
    import resp_pkg::*;
#(
    parameter int NUM_REQ  = RESP_NUM_REQ,
    parameter int GNT_DLY  = RESP_GNT_DLY,
    parameter int MAX_HOLD = RESP_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    resp_grant_responder_if.slave bus
`ifdef RESP_STATS_EN
    ,
    output logic [15:0]           grant_cnt,
    output logic [15:0]           abort_cnt,
    output logic [15:0]           timeout_cnt
`endif
);

    localparam int              IW        = resp_idx_w(NUM_REQ);
    localparam logic [3:0]      CNT_LAST  = 4'(GNT_DLY - 1);
    localparam logic [7:0]      HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [IW-1:0]   LAST_INIT = IW'(NUM_REQ - 1);

    resp_state_t        state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_owner_q, last_owner_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         hold_q, hold_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               abort_q, abort_d;
    logic               timeout_q, timeout_d;
    logic               arb_valid;
    logic [IW-1:0]      arb_idx;
    logic               own_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i        (bus.request),
        .last_owner_i (last_owner_q),
        .valid_o      (arb_valid),
        .idx_o        (arb_idx)
    );

    assign own_req = bus.request[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_INIT;
            cnt_q        <= '0;
            hold_q       <= '0;
            grant_q      <= '0;
            abort_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            grant_q      <= grant_d;
            abort_q      <= abort_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        grant_d      = grant_q;
        abort_d      = 1'b0;
        timeout_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                cnt_d   = '0;
                hold_d  = '0;
                if (arb_valid) begin
                    owner_d = arb_idx;
                    cnt_d   = 4'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!own_req) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    grant_d          = '0;
                    grant_d[owner_q] = 1'b1;
                    hold_d           = '0;
                    state_d          = GRANT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                    hold_d       = '0;
                    state_d      = IDLE;
                end else if (hold_q == HOLD_MAX) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = BACKOFF;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            BACKOFF: begin
                // Owner must let go before anyone, itself included, can be served again.
                grant_d = '0;
                if (!own_req) begin
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                    hold_d       = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.owner     = owner_q;
    assign bus.abort_p   = abort_q;
    assign bus.timeout_p = timeout_q;

`ifdef RESP_STATS_EN
    logic grant_done;
    assign grant_done = (state_q == GRANT) && !own_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt   <= '0;
            abort_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (grant_done && grant_cnt != 16'hFFFF)  grant_cnt   <= grant_cnt + 16'd1;
            if (abort_d && abort_cnt != 16'hFFFF)     abort_cnt   <= abort_cnt + 16'd1;
            if (timeout_d && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_resp_grant_responder.sv
// tb/tb_resp_grant_responder.sv - directed and randomized checks of resp_grant_responder against a timeline model
module tb_resp_grant_responder;
    import resp_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int GNT_DLY  = 3;
    localparam int MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    resp_grant_responder_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef RESP_STATS_EN
    logic [15:0] grant_cnt, abort_cnt, timeout_cnt;
`endif

    resp_grant_responder #(
        .NUM_REQ  (NUM_REQ),
        .GNT_DLY  (GNT_DLY),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RESP_STATS_EN
        ,
        .grant_cnt   (grant_cnt),
        .abort_cnt   (abort_cnt),
        .timeout_cnt (timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: each service is a timeline measured in edges from the arbitration edge.
    bit               m_active, m_backoff;
    int               m_owner, m_last, m_start, edge_no;
    int               m_grants, m_aborts, m_timeouts;
    logic [NUM_REQ-1:0] exp_grant;
    logic             exp_abort, exp_timeout;

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_backoff = 0; m_owner = 0; m_last = NUM_REQ - 1; m_start = 0;
        m_grants = 0; m_aborts = 0; m_timeouts = 0;
        exp_grant = '0; exp_abort = 1'b0; exp_timeout = 1'b0;
    endtask

    task automatic model_edge(input logic [NUM_REQ-1:0] r);
        int a;
        exp_abort   = 1'b0;
        exp_timeout = 1'b0;
        if (!m_active) begin
            if (r != '0) begin
                m_owner = rr_pick(r, m_last); m_active = 1; m_backoff = 0; m_start = edge_no;
            end
        end else begin
            a = edge_no - m_start;
            if (m_backoff) begin
                if (!r[m_owner]) begin m_last = m_owner; m_active = 0; end
            end else if (a < GNT_DLY) begin
                if (!r[m_owner]) begin exp_abort = 1'b1; m_aborts++; m_active = 0; end
                else if (a == GNT_DLY - 1) begin exp_grant = '0; exp_grant[m_owner] = 1'b1; end
            end else if (!r[m_owner]) begin
                exp_grant = '0; m_last = m_owner; m_active = 0; m_grants++;
            end else if (a - (GNT_DLY - 1) == MAX_HOLD + 1) begin
                exp_grant = '0; exp_timeout = 1'b1; m_timeouts++; m_backoff = 1;
            end
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] r;
        @(posedge clk);
        r = bus.request;
        edge_no++;
        model_edge(r);
        #1;
        checks++;
        if (bus.grant !== exp_grant) begin
            errors++; $display("FAIL grant edge %0d got %b exp %b", edge_no, bus.grant, exp_grant);
        end
        checks++;
        if (bus.busy !== logic'(m_active)) begin
            errors++; $display("FAIL busy edge %0d got %b exp %b", edge_no, bus.busy, m_active);
        end
        checks++;
        if (bus.abort_p !== exp_abort) begin
            errors++; $display("FAIL abort_p edge %0d got %b exp %b", edge_no, bus.abort_p, exp_abort);
        end
        checks++;
        if (bus.timeout_p !== exp_timeout) begin
            errors++; $display("FAIL timeout_p edge %0d got %b exp %b", edge_no, bus.timeout_p, exp_timeout);
        end
        if (m_active) begin
            checks++;
            if (bus.owner !== 2'(m_owner)) begin
                errors++; $display("FAIL owner edge %0d got %0d exp %0d", edge_no, bus.owner, m_owner);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic settle();
        bus.request = '0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        bus.request = '0;
        model_reset();
        #12;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", bus.owner); end
        checks++; if (bus.abort_p !== 1'b0) begin errors++; $display("FAIL reset_abort got %b exp 0", bus.abort_p); end
        checks++; if (bus.timeout_p !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.timeout_p); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_nominal();
        logic [4:0] seq;
        logic       pulses;
        int         lat;
        pulses = 1'b0;
        bus.request = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.request = 4'b0000;
            step();
            seq[i] = bus.grant[0];
            pulses = pulses | bus.abort_p | bus.timeout_p;
        end
        checks++; if (seq !== 5'b01100) begin errors++; $display("FAIL nominal_seq got %b exp 01100 (lsb first)", seq); end
        checks++; if (pulses !== 1'b0) begin errors++; $display("FAIL nominal_pulses got %b exp 0", pulses); end
        bus.request = 4'b0001;
        lat = 0;
        while (bus.grant[0] !== 1'b1 && lat < 10) begin step(); lat++; end
        checks++; if (lat != GNT_DLY) begin errors++; $display("FAIL nominal_regrant_latency got %0d exp %0d", lat, GNT_DLY); end
        settle();
    endtask

    task automatic test_abort();
        int aborts, grants;
        do_reset();
        aborts = 0; grants = 0;
        bus.request = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) bus.request = 4'b0000;
            step();
            if (bus.abort_p === 1'b1) aborts++;
            if (bus.grant !== 4'b0000) grants++;
        end
        checks++; if (aborts != 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", aborts); end
        checks++; if (grants != 0) begin errors++; $display("FAIL abort_grants got %0d exp 0", grants); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
`ifdef RESP_STATS_EN
        checks++; if (abort_cnt !== 16'd1) begin errors++; $display("FAIL abort_cnt got %0d exp 1", abort_cnt); end
`endif
    endtask

    task automatic test_fairness();
        int   order[$];
        bit   seen[NUM_REQ];
        bit   overlap;
        logic [NUM_REQ-1:0] prev;
        int   exp_order[4] = '{0, 2, 0, 2};
        do_reset();
        bus.request = 4'b0101;
        overlap = 0; prev = '0;
        for (int k = 0; k < NUM_REQ; k++) seen[k] = 0;
        for (int n = 0; n < 60 && order.size() < 4; n++) begin
            step();
            if ($countones(bus.grant) > 1) overlap = 1;
            for (int k = 0; k < NUM_REQ; k++) if (bus.grant[k] && !prev[k]) order.push_back(k);
            prev = bus.grant;
            for (int k = 0; k < NUM_REQ; k += 2) begin
                if (bus.grant[k]) begin
                    if (seen[k]) bus.request[k] = 1'b0; else seen[k] = 1;
                end else if (!bus.request[k]) begin
                    bus.request[k] = 1'b1; seen[k] = 0;
                end
            end
        end
        checks++; if (order.size() != 4) begin errors++; $display("FAIL fair_count got %0d exp 4", order.size()); end
        for (int k = 0; k < 4 && k < order.size(); k++) begin
            checks++;
            if (order[k] != exp_order[k]) begin errors++; $display("FAIL fair_order[%0d] got %0d exp %0d", k, order[k], exp_order[k]); end
        end
        checks++; if (overlap) begin errors++; $display("FAIL fair_onehot got overlap exp none"); end
        settle();
    endtask

    task automatic test_timeout();
        int  high, tos, regrant;
        bit  after_to, to_grant_bad;
        high = 0; tos = 0; regrant = 0; after_to = 0; to_grant_bad = 0;
        bus.request = 4'b1000;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.grant[3] === 1'b1) begin high++; if (after_to) regrant++; end
            if (bus.timeout_p === 1'b1) begin tos++; after_to = 1; if (bus.grant !== 4'b0000) to_grant_bad = 1; end
        end
        checks++; if (high != MAX_HOLD + 1) begin errors++; $display("FAIL timeout_high got %0d exp %0d", high, MAX_HOLD + 1); end
        checks++; if (tos != 1) begin errors++; $display("FAIL timeout_pulses got %0d exp 1", tos); end
        checks++; if (to_grant_bad) begin errors++; $display("FAIL timeout_grant_same_cycle got nonzero exp 0000"); end
        checks++; if (regrant != 0) begin errors++; $display("FAIL timeout_regrant got %0d exp 0", regrant); end
        bus.request = 4'b0000;
        repeat (2) step();
        bus.request = 4'b1000;
        repeat (GNT_DLY) step();
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL timeout_reraise got %b exp 1000", bus.grant); end
        settle();
    endtask

    task automatic test_reset_mid_grant();
        int n;
        bus.request = 4'b0001;
        n = 0;
        while (bus.grant[0] !== 1'b1 && n < 10) begin step(); n++; end
        checks++; if (bus.grant[0] !== 1'b1) begin errors++; $display("FAIL rstmid_no_grant got %b exp 1", bus.grant[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rstmid_grant got %b exp 0000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL rstmid_early got %b exp 0000", bus.grant); end
        step();
        checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL rstmid_regrant got %b exp 0001", bus.grant); end
        settle();
    endtask

    task automatic test_random();
        do_reset();
        bus.request = '0;
        for (int n = 0; n < 400; n++) begin
            step();
            for (int k = 0; k < NUM_REQ; k++)
                if ($urandom_range(7) == 0) bus.request[k] = ~bus.request[k];
        end
`ifdef RESP_STATS_EN
        checks++; if (grant_cnt !== 16'(m_grants)) begin errors++; $display("FAIL stat_grant got %0d exp %0d", grant_cnt, m_grants); end
        checks++; if (abort_cnt !== 16'(m_aborts)) begin errors++; $display("FAIL stat_abort got %0d exp %0d", abort_cnt, m_aborts); end
        checks++; if (timeout_cnt !== 16'(m_timeouts)) begin errors++; $display("FAIL stat_timeout got %0d exp %0d", timeout_cnt, m_timeouts); end
`endif
        settle();
    endtask

    initial begin
        edge_no = 0;
        bus.request = '0;
        test_reset();
        test_nominal();
        test_abort();
        test_fairness();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
